pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It owns per-stage valid/rd/write-enable/load tracking for EX, MEM and WB, and computes EX operand forwarding selects, load-use and multi-cycle stalls, and branch/jump redirect flushes. It sits beside the decoder: the decoder supplies ID-stage register usage, and this block returns stall, flush and forward controls to the pipeline registers and the EX operand muxes.

## Interface
- REG_AW, 5: register address width (4 for RV32E).
- FWD_EN, 1: 1 = forward from MEM/WB; 0 = interlock only, stall until the producer retires.
- MC_LAT, 4: EX occupancy in cycles of a multi-cycle op (mul/div), ≥2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read (0 for LUI/JAL etc.).
- id_rd  in  REG_AW  ID destination.
- id_reg_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_mc  in  1  ID instruction is multi-cycle in EX.
- id_is_store  in  1  ID instruction is a store (rs2 is store data).
- mem_redirect  in  1  MEM resolved taken branch/jump (PCSel).
- stall_if, stall_id  out  1  hold PC / IF-ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- stall_ex  out  1  hold ID/EX register (multi-cycle busy).
- flush_id, flush_ex  out  1  squash IF/ID, ID/EX contents.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 MEM, 01 WB.
- fwd_st  out  2  EX store-data select, same encoding; fwd_b is 00 when EX is a store.
- ex_rd, mem_rd, wb_rd  out  REG_AW  tracked destinations (debug/regfile).
- wb_wen  out  1  WB-stage write enable, gated by valid.

## Operation
- Tracking registers per stage S in {EX, MEM, WB}: vld, rd, wen, load, store, mc, rs1, rs2. Advance ID→EX→MEM→WB each cycle unless held; bubble inserts vld=0.
- Writer match: stage valid, wen, rd≠0, rd==source, use flag set.
- FWD_EN=1: fwd_a from EX rs1: MEM match → 10, else WB match → 01, else 00. Same for rs2 into fwd_b (non-store) or fwd_st (store). MEM has priority (youngest value).
- Load-use: ID source matches EX writer with load=1 → stall_if=stall_id=bubble_ex=1 for exactly one cycle.
- FWD_EN=0: ID source matching any EX, MEM or WB writer → stall_if/stall_id/bubble_ex; fwd_* constant 00.
- Multi-cycle: op entering EX with mc=1 loads busy counter with MC_LAT-1. While counter≠0: stall_ex=stall_id=stall_if=1, EX does not advance, MEM receives bubble. Counter decrements each cycle; at 0, EX advances normally.
- Redirect: mem_redirect=1 → flush_id=flush_ex=1, EX vld cleared, busy counter cleared, MEM advances into WB. Redirect overrides every stall (stall_*=0, bubble_ex=0 that cycle).
- Simultaneous load-use + multi-cycle busy: busy stall wins; the load-use check re-evaluates once EX advances.
- x0 never matches; id_valid=0 never stalls.

## Timing
- All outputs except tracking registers are combinational from current state and ID inputs; no added latency.
- Load-use costs 1 cycle (FWD_EN=1); FWD_EN=0 RAW costs up to 3 cycles.
- Multi-cycle op occupies EX for exactly MC_LAT cycles.
- Reset (asynchronous, any time, including mid-busy): all vld=0, counter=0, rd fields 0; consequently all stall/flush/bubble=0, fwd_*=00, wb_wen=0 while rst_n=0 and the first cycle after.

## Structure
- Shared package (pipe_pkg): forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10; stage-tracking struct (vld, rd, wen, load, store, mc, rs1, rs2).
- One sub-module: fwd_select (combinational priority compare, instanced three times for a, b, st).

## Test plan
- add x1; add x2,x1,x3 back-to-back (FWD_EN=1) → fwd_a=10 in EX of second, no stall.
- lw x5; add x6,x5,x5 → one cycle stall_if/stall_id/bubble_ex, then fwd_a=fwd_b=01.
- FWD_EN=0, addi x7; sub x8,x7,x0 → 3 stall cycles, fwd_*=00 throughout.
- mul x9 (MC_LAT=4) followed by add → stall_ex high 3 cycles, EX occupied 4, add receives fwd_a=10.
- Taken beq reaches MEM while mul busy → flush_id=flush_ex=1, stall_*=0, counter cleared.
- rst_n low mid-busy → all outputs 0/00 asynchronously; sw x4 after addi x4 → fwd_st=10, fwd_b=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the 5-stage pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] rd;
    logic            wen;
    logic            load;
    logic            store;
    logic            mc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
  } stage_t;

  // Unused sources are carried as x0, so the rd != 0 test also covers the use flags.
  function automatic logic hit(input logic wr, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] src);
    return wr && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forward select for one EX operand; MEM (youngest) beats WB beats regfile.
// Purely combinational; forced to regfile when forwarding is disabled.
module fwd_select
  import pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0] i_src,
  input  logic            i_mem_wr,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_wb_wr,
  input  logic [RA_W-1:0] i_wb_rd,
  output logic [1:0]      o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (FWD_EN) begin
      if (hit(i_mem_wr, i_mem_rd, i_src))     o_sel = FWD_MEM;
      else if (hit(i_wb_wr, i_wb_rd, i_src))  o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for the IF/ID/EX/MEM/WB pipeline.
// Tracks EX/MEM/WB occupancy; stall/flush/forward outputs are combinational from that state.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wen,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              id_is_store,
  input  logic              mem_redirect,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_st,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_wen
);

  localparam int            CW       = $clog2(MC_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);

  stage_t          r_ex, r_mem, r_wb, w_id;
  logic [CW-1:0]   r_cnt;
  logic [RA_W-1:0] w_id_rs1, w_id_rs2, w_b_src, w_st_src;
  logic            w_ex_wr, w_mem_wr, w_wb_wr;
  logic            w_busy, w_redirect, w_raw;
  logic            w_unused;

  assign w_id_rs1 = id_use_rs1 ? RA_W'(id_rs1) : '0;
  assign w_id_rs2 = id_use_rs2 ? RA_W'(id_rs2) : '0;

  always_comb begin
    w_id = '0;
    if (id_valid) begin
      w_id.vld   = 1'b1;
      w_id.rd    = RA_W'(id_rd);
      w_id.wen   = id_reg_wen;
      w_id.load  = id_is_load;
      w_id.store = id_is_store;
      w_id.mc    = id_is_mc;
      w_id.rs1   = w_id_rs1;
      w_id.rs2   = w_id_rs2;
    end
  end

  assign w_ex_wr  = r_ex.vld  & r_ex.wen;
  assign w_mem_wr = r_mem.vld & r_mem.wen;
  assign w_wb_wr  = r_wb.vld  & r_wb.wen;

  // A redirect only counts when MEM actually holds the resolving branch.
  assign w_redirect = mem_redirect & r_mem.vld;
  assign w_busy     = (r_cnt != '0);

  always_comb begin
    w_raw = 1'b0;
    if (id_valid) begin
      if (FWD_EN) begin
        w_raw = r_ex.load && (hit(w_ex_wr, r_ex.rd, w_id_rs1) || hit(w_ex_wr, r_ex.rd, w_id_rs2));
      end else begin
        w_raw = hit(w_ex_wr,  r_ex.rd,  w_id_rs1) || hit(w_ex_wr,  r_ex.rd,  w_id_rs2) ||
                hit(w_mem_wr, r_mem.rd, w_id_rs1) || hit(w_mem_wr, r_mem.rd, w_id_rs2) ||
                hit(w_wb_wr,  r_wb.rd,  w_id_rs1) || hit(w_wb_wr,  r_wb.rd,  w_id_rs2);
      end
    end
  end

  assign stall_ex  = w_busy & ~w_redirect;
  assign stall_id  = (w_busy | w_raw) & ~w_redirect;
  assign stall_if  = stall_id;
  assign bubble_ex = w_raw & ~w_busy & ~w_redirect;
  assign flush_id  = w_redirect;
  assign flush_ex  = w_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_wb <= r_mem;
      if (w_redirect) begin
        r_mem <= '0;
        r_ex  <= '0;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_mem <= '0;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_mem <= r_ex;
        r_ex  <= w_raw ? '0 : w_id;
        r_cnt <= (!w_raw && w_id.vld && w_id.mc) ? CNT_LOAD : '0;
      end
    end
  end

  // Store data travels on its own select, so rs2 is steered to exactly one of b/st.
  assign w_b_src  = r_ex.store ? '0 : r_ex.rs2;
  assign w_st_src = r_ex.store ? r_ex.rs2 : '0;

  fwd_select #(.FWD_EN(FWD_EN)) u_fwd_a (
    .i_src(r_ex.rs1), .i_mem_wr(w_mem_wr), .i_mem_rd(r_mem.rd),
    .i_wb_wr(w_wb_wr), .i_wb_rd(r_wb.rd), .o_sel(fwd_a));

  fwd_select #(.FWD_EN(FWD_EN)) u_fwd_b (
    .i_src(w_b_src), .i_mem_wr(w_mem_wr), .i_mem_rd(r_mem.rd),
    .i_wb_wr(w_wb_wr), .i_wb_rd(r_wb.rd), .o_sel(fwd_b));

  fwd_select #(.FWD_EN(FWD_EN)) u_fwd_st (
    .i_src(w_st_src), .i_mem_wr(w_mem_wr), .i_mem_rd(r_mem.rd),
    .i_wb_wr(w_wb_wr), .i_wb_rd(r_wb.rd), .o_sel(fwd_st));

  assign ex_rd  = r_ex.rd[REG_AW-1:0];
  assign mem_rd = r_mem.rd[REG_AW-1:0];
  assign wb_rd  = r_wb.rd[REG_AW-1:0];
  assign wb_wen = w_wb_wr;

  // Downstream stages keep the full record for debug visibility only.
  assign w_unused = ^{r_ex.mc, r_mem, r_wb};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: forwarding instance (f_) and interlock-only instance (n_) share ID inputs.
module tb_pipe_hazard_ctrl;

  logic       clk, rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wen, id_is_load, id_is_mc, id_is_store;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       mem_redirect;

  logic       f_stall_if, f_stall_id, f_bubble_ex, f_stall_ex, f_flush_id, f_flush_ex, f_wb_wen;
  logic [1:0] f_fwd_a, f_fwd_b, f_fwd_st;
  logic [4:0] f_ex_rd, f_mem_rd, f_wb_rd;
  logic       n_stall_if, n_stall_id, n_bubble_ex, n_stall_ex, n_flush_id, n_flush_ex, n_wb_wen;
  logic [1:0] n_fwd_a, n_fwd_b, n_fwd_st;
  logic [4:0] n_ex_rd, n_mem_rd, n_wb_rd;
  logic [12:0] f_ctl;

  int checks = 0;
  int errors = 0;
  int n;

  assign f_ctl = {f_stall_if, f_stall_id, f_bubble_ex, f_stall_ex, f_flush_id, f_flush_ex,
                  f_fwd_a, f_fwd_b, f_fwd_st, f_wb_wen};

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .MC_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .id_is_store(id_is_store),
    .mem_redirect(mem_redirect), .stall_if(f_stall_if), .stall_id(f_stall_id),
    .bubble_ex(f_bubble_ex), .stall_ex(f_stall_ex), .flush_id(f_flush_id), .flush_ex(f_flush_ex),
    .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .fwd_st(f_fwd_st), .ex_rd(f_ex_rd), .mem_rd(f_mem_rd),
    .wb_rd(f_wb_rd), .wb_wen(f_wb_wen));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .MC_LAT(4)) dut_nf (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .id_is_store(id_is_store),
    .mem_redirect(mem_redirect), .stall_if(n_stall_if), .stall_id(n_stall_id),
    .bubble_ex(n_bubble_ex), .stall_ex(n_stall_ex), .flush_id(n_flush_id), .flush_ex(n_flush_ex),
    .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .fwd_st(n_fwd_st), .ex_rd(n_ex_rd), .mem_rd(n_mem_rd),
    .wb_rd(n_wb_rd), .wb_wen(n_wb_wen));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_wen = 1'b0;
    id_is_load = 1'b0; id_is_mc = 1'b0; id_is_store = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic wen,
                       input logic ld, input logic mc, input logic st);
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_wen = wen;
    id_is_load = ld; id_is_mc = mc; id_is_store = st;
  endtask

  task automatic do_reset();
    idle();
    mem_redirect = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    mem_redirect = 1'b1;
    #3;
    checks++; if (f_ctl !== 13'b0) begin errors++; $display("FAIL reset_ctl got %b want 0", f_ctl); end
    checks++; if ({f_ex_rd, f_mem_rd, f_wb_rd} !== 15'b0) begin errors++; $display("FAIL reset_rd got %h want 0", {f_ex_rd, f_mem_rd, f_wb_rd}); end
    mem_redirect = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (f_ctl !== 13'b0) begin errors++; $display("FAIL reset_after_ctl got %b want 0", f_ctl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
    tick();
    issue(5'd2, 5'd1, 5'd3, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if ({f_stall_if, f_bubble_ex} !== 2'b00) begin errors++; $display("FAIL b2b_nostall got %b want 00", {f_stall_if, f_bubble_ex}); end
    checks++; if (n_stall_if !== 1'b1) begin errors++; $display("FAIL b2b_interlock_stall got %b want 1", n_stall_if); end
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_a, f_fwd_b} !== 4'b1000) begin errors++; $display("FAIL b2b_fwd got %b want 1000", {f_fwd_a, f_fwd_b}); end
    checks++; if ({f_ex_rd, f_mem_rd} !== {5'd2, 5'd1}) begin errors++; $display("FAIL b2b_rd got %h want %h", {f_ex_rd, f_mem_rd}, {5'd2, 5'd1}); end
    tick();
    #1;
    checks++; if ({f_wb_wen, f_wb_rd} !== {1'b1, 5'd1}) begin errors++; $display("FAIL b2b_wb got %b want %b", {f_wb_wen, f_wb_rd}, {1'b1, 5'd1}); end
    // x0 as destination must never create a dependency.
    do_reset();
    issue(5'd0, 5'd1, 5'd0, 1, 0, 1, 0, 0, 0);
    tick();
    issue(5'd3, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if (n_stall_if !== 1'b0) begin errors++; $display("FAIL x0_nostall got %b want 0", n_stall_if); end
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_nofwd got %b want 0000", {f_fwd_a, f_fwd_b}); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 0, 0);
    tick();
    issue(5'd6, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if ({f_stall_if, f_stall_id, f_bubble_ex, f_stall_ex} !== 4'b1110) begin errors++; $display("FAIL lu_stall got %b want 1110", {f_stall_if, f_stall_id, f_bubble_ex, f_stall_ex}); end
    tick();
    #1;
    checks++; if ({f_stall_if, f_stall_id, f_bubble_ex} !== 3'b000) begin errors++; $display("FAIL lu_release got %b want 000", {f_stall_if, f_stall_id, f_bubble_ex}); end
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0101) begin errors++; $display("FAIL lu_fwd got %b want 0101", {f_fwd_a, f_fwd_b}); end
    checks++; if ({f_ex_rd, f_mem_rd, f_wb_rd} !== {5'd6, 5'd0, 5'd5}) begin errors++; $display("FAIL lu_rd got %h want %h", {f_ex_rd, f_mem_rd, f_wb_rd}, {5'd6, 5'd0, 5'd5}); end
    // An invalid ID slot never stalls even if its fields look dependent.
    do_reset();
    issue(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 0, 0);
    tick();
    issue(5'd6, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0);
    id_valid = 1'b0;
    #1;
    checks++; if ({f_stall_if, f_bubble_ex} !== 2'b00) begin errors++; $display("FAIL idinv_nostall got %b want 00", {f_stall_if, f_bubble_ex}); end
  endtask

  task automatic test_interlock();
    do_reset();
    issue(5'd7, 5'd1, 5'd0, 1, 0, 1, 0, 0, 0);
    tick();
    issue(5'd8, 5'd7, 5'd0, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL il_fwd_nostall got %b want 0", f_stall_if); end
    n = 0;
    while (n_stall_if && n < 8) begin
      checks++; if ({n_bubble_ex, n_fwd_a, n_fwd_b, n_fwd_st} !== 7'b1000000) begin errors++; $display("FAIL il_stall_cycle%0d got %b want 1000000", n, {n_bubble_ex, n_fwd_a, n_fwd_b, n_fwd_st}); end
      n++;
      tick();
      #1;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL il_stall_cycles got %0d want 3", n); end
    tick();
    idle();
    #1;
    checks++; if ({n_ex_rd, n_fwd_a} !== {5'd8, 2'b00}) begin errors++; $display("FAIL il_ex got %b want %b", {n_ex_rd, n_fwd_a}, {5'd8, 2'b00}); end
  endtask

  task automatic test_multicycle();
    do_reset();
    issue(5'd9, 5'd1, 5'd2, 1, 1, 1, 0, 1, 0);
    tick();
    issue(5'd10, 5'd9, 5'd3, 1, 1, 1, 0, 0, 0);
    n = 0;
    #1;
    while (f_stall_ex && n < 8) begin
      checks++; if ({f_stall_if, f_stall_id, f_bubble_ex, f_ex_rd} !== {3'b110, 5'd9}) begin errors++; $display("FAIL mc_busy_cycle%0d got %b want %b", n, {f_stall_if, f_stall_id, f_bubble_ex, f_ex_rd}, {3'b110, 5'd9}); end
      n++;
      tick();
      #1;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL mc_stall_cycles got %0d want 3", n); end
    checks++; if ({f_ex_rd, f_stall_id} !== {5'd9, 1'b0}) begin errors++; $display("FAIL mc_last_cycle got %b want %b", {f_ex_rd, f_stall_id}, {5'd9, 1'b0}); end
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_a, f_ex_rd, f_mem_rd} !== {2'b10, 5'd10, 5'd9}) begin errors++; $display("FAIL mc_fwd got %b want %b", {f_fwd_a, f_ex_rd, f_mem_rd}, {2'b10, 5'd10, 5'd9}); end
  endtask

  task automatic test_redirect();
    do_reset();
    issue(5'd0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0);
    tick();
    issue(5'd9, 5'd1, 5'd2, 1, 1, 1, 0, 1, 0);
    tick();
    issue(5'd11, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0);
    mem_redirect = 1'b1;
    #1;
    checks++; if ({f_flush_id, f_flush_ex} !== 2'b11) begin errors++; $display("FAIL rd_flush got %b want 11", {f_flush_id, f_flush_ex}); end
    checks++; if ({f_stall_if, f_stall_id, f_stall_ex, f_bubble_ex} !== 4'b0000) begin errors++; $display("FAIL rd_nostall got %b want 0000", {f_stall_if, f_stall_id, f_stall_ex, f_bubble_ex}); end
    tick();
    mem_redirect = 1'b0;
    idle();
    #1;
    checks++; if ({f_stall_ex, f_flush_id, f_ex_rd, f_mem_rd} !== 12'b0) begin errors++; $display("FAIL rd_cleared got %b want 0", {f_stall_ex, f_flush_id, f_ex_rd, f_mem_rd}); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    issue(5'd9, 5'd1, 5'd2, 1, 1, 1, 0, 1, 0);
    tick();
    issue(5'd9, 5'd9, 5'd0, 1, 0, 1, 0, 0, 0);
    #1;
    checks++; if (f_stall_ex !== 1'b1) begin errors++; $display("FAIL rmb_busy got %b want 1", f_stall_ex); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({f_ctl, f_ex_rd} !== 18'b0) begin errors++; $display("FAIL rmb_async got %b want 0", {f_ctl, f_ex_rd}); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (f_ctl !== 13'b0) begin errors++; $display("FAIL rmb_after got %b want 0", f_ctl); end
  endtask

  task automatic test_store_fwd();
    do_reset();
    issue(5'd4, 5'd1, 5'd0, 1, 0, 1, 0, 0, 0);
    tick();
    issue(5'd0, 5'd5, 5'd4, 1, 1, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_st, f_fwd_b, f_fwd_a} !== 6'b100000) begin errors++; $display("FAIL st_mem got %b want 100000", {f_fwd_st, f_fwd_b, f_fwd_a}); end
    do_reset();
    issue(5'd4, 5'd1, 5'd0, 1, 0, 1, 0, 0, 0);
    tick();
    idle();
    tick();
    issue(5'd0, 5'd5, 5'd4, 1, 1, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    checks++; if ({f_fwd_st, f_fwd_b} !== 4'b0100) begin errors++; $display("FAIL st_wb got %b want 0100", {f_fwd_st, f_fwd_b}); end
  endtask

  initial begin
    idle();
    mem_redirect = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_interlock();
    test_multicycle();
    test_redirect();
    test_reset_mid_busy();
    test_store_fwd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
